// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer and its condition checker.
package ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 4;

  // State encodings; anything not listed here is unreachable.
  localparam logic [STATE_W-1:0] ST_FETCH  = 4'd0;
  localparam logic [STATE_W-1:0] ST_DECODE = 4'd1;
  localparam logic [STATE_W-1:0] ST_MEMADR = 4'd2;
  localparam logic [STATE_W-1:0] ST_MEMRD  = 4'd3;
  localparam logic [STATE_W-1:0] ST_MEMWB  = 4'd4;
  localparam logic [STATE_W-1:0] ST_MEMWR  = 4'd5;
  localparam logic [STATE_W-1:0] ST_EXECR  = 4'd6;
  localparam logic [STATE_W-1:0] ST_EXECI  = 4'd7;
  localparam logic [STATE_W-1:0] ST_EXECM  = 4'd8;
  localparam logic [STATE_W-1:0] ST_ALUWB  = 4'd9;
  localparam logic [STATE_W-1:0] ST_BRANCH = 4'd10;

  // Instruction condition field.
  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_CS = 4'h2;
  localparam logic [COND_W-1:0] COND_CC = 4'h3;
  localparam logic [COND_W-1:0] COND_MI = 4'h4;
  localparam logic [COND_W-1:0] COND_PL = 4'h5;
  localparam logic [COND_W-1:0] COND_VS = 4'h6;
  localparam logic [COND_W-1:0] COND_VC = 4'h7;
  localparam logic [COND_W-1:0] COND_HI = 4'h8;
  localparam logic [COND_W-1:0] COND_LS = 4'h9;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;
  localparam logic [COND_W-1:0] COND_AL = 4'hE;
  localparam logic [COND_W-1:0] COND_NV = 4'hF;

  // Instruction class from Instr[27:26].
  localparam logic [OP_W-1:0] OP_DP  = 2'b00;
  localparam logic [OP_W-1:0] OP_MEM = 2'b01;
  localparam logic [OP_W-1:0] OP_BR  = 2'b10;
  localparam logic [OP_W-1:0] OP_ILL = 2'b11;

  // Datapath mux selects.
  localparam logic             ADR_PC         = 1'b0;
  localparam logic             ADR_ALUOUT     = 1'b1;
  localparam logic             SRCA_RD1       = 1'b0;
  localparam logic             SRCA_PC        = 1'b1;
  localparam logic [SEL_W-1:0] SRCB_RD2       = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_EXTIMM    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR      = 2'b10;
  localparam logic [SEL_W-1:0] RES_ALUOUT     = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA       = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT  = 2'b10;

  // Bit positions inside the {N,Z,C,V} flag word.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluation against the {N,Z,C,V} flags.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [COND_W-1:0] Cond,
  input  logic [FLAG_W-1:0] Flags,
  output logic              CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  // Decode the condition field; NV is treated as never-execute.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer: steps each instruction through its cycles and
// drives the datapath enables/selects, NZCV flag register and memory handshake.
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COND_W-1:0] Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [OP_W-1:0]   Op,
  input  logic              FunctI,
  input  logic              FunctL,
  input  logic              mul,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              mem_ready,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [SEL_W-1:0]  ALUSrcB,
  output logic [SEL_W-1:0]  ResultSrc,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [FLAG_W-1:0] Flags,
  output logic              illegal,
  output logic [STATE_W-1:0] state_o
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic               cond_ex_q, cond_ex_d;
  logic               cond_ex;
  logic               flag_upd;
  logic               ir_write_c, pc_write_c, reg_write_c, mem_write_c, illegal_c;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  // State, flags, multiply counter and latched condition result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      flags_q   <= '0;
      mul_cnt_q <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      mul_cnt_q <= mul_cnt_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Next-state logic and per-state datapath controls.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    mul_cnt_d   = mul_cnt_q;
    cond_ex_d   = cond_ex_q;
    flag_upd    = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    illegal_c   = 1'b0;
    AdrSrc      = ADR_PC;
    ALUSrcA     = SRCA_RD1;
    ALUSrcB     = SRCB_RD2;
    ResultSrc   = RES_ALUOUT;

    case (state_q)
      ST_FETCH: begin
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        cond_ex_d = cond_ex;
        if (!cond_ex) begin
          state_d = ST_FETCH;
        end else begin
          case (Op)
            OP_ILL: begin
              state_d   = ST_FETCH;
              illegal_c = 1'b1;
            end
            OP_MEM: state_d = ST_MEMADR;
            OP_BR:  state_d = ST_BRANCH;
            default: begin
              if (mul) begin
                state_d   = ST_EXECM;
                mul_cnt_d = CNT_W'(MUL_LAT - 1);
              end else if (FunctI) begin
                state_d = ST_EXECI;
              end else begin
                state_d = ST_EXECR;
              end
            end
          endcase
        end
      end
      ST_MEMADR: begin
        ALUSrcB = SRCB_EXTIMM;
        state_d = FunctL ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        AdrSrc = ADR_ALUOUT;
        if (mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_c = 1'b1;
        pc_write_c  = PCS;
        state_d     = ST_FETCH;
      end
      ST_MEMWR: begin
        AdrSrc      = ADR_ALUOUT;
        mem_write_c = MemW;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_EXECR: begin
        flag_upd = 1'b1;
        state_d  = ST_ALUWB;
      end
      ST_EXECI: begin
        ALUSrcB  = SRCB_EXTIMM;
        flag_upd = 1'b1;
        state_d  = ST_ALUWB;
      end
      ST_EXECM: begin
        if (mul_cnt_q == '0) begin
          flag_upd = 1'b1;
          state_d  = ST_ALUWB;
        end else begin
          mul_cnt_d = mul_cnt_q - CNT_W'(1);
        end
      end
      ST_ALUWB: begin
        reg_write_c = RegW;
        pc_write_c  = PCS;
        state_d     = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcB    = SRCB_EXTIMM;
        ResultSrc  = RES_ALURESULT;
        pc_write_c = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Flag write in the last execute cycle of an executed instruction.
    if (flag_upd && cond_ex_q) begin
      if (FlagW[1]) begin
        flags_d[FLAG_N] = ALUFlags[FLAG_N];
        flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
      end
      if (FlagW[0]) begin
        flags_d[FLAG_C] = ALUFlags[FLAG_C];
        flags_d[FLAG_V] = ALUFlags[FLAG_V];
      end
    end
  end

  // Enables are forced low for the whole time reset is held, so an access
  // interrupted by reset never commits a partial write.
  assign IRWrite  = ir_write_c  & ~reset;
  assign PCWrite  = pc_write_c  & ~reset;
  assign RegWrite = reg_write_c & ~reset;
  assign MemWrite = mem_write_c & ~reset;
  assign illegal  = illegal_c   & ~reset;
  assign Flags    = flags_q;
  assign state_o  = state_q;

endmodule
